// File: rtl/alu_muldiv_seq.sv
// -----------------------------------------------------------------------------
// alu_muldiv_seq
//
// Multicycle signed multiply/divide sequencer. It borrows the processor's
// 32-bit combinational ALU while an operation runs. Multiply is 32-step
// radix-2 Booth using ALU add/sub. Divide is restoring division on operand
// magnitudes. Sign fix-up also goes through the ALU (0 - x).
//
// Ports
//   clock, reset_n            rising-edge clock, async active-low reset
//   ctrl_MULT, ctrl_DIV       start requests, sampled at the rising edge
//   data_operandA/B [31:0]    multiplicand/dividend, multiplier/divisor
//   alu_opA/B [31:0]          ALU operand drive
//   alu_opcode [4:0]          00000 add, 00001 sub
//   alu_shamt [4:0]           always zero
//   alu_result [31:0]         ALU result, same cycle
//   alu_overflow              ALU signed overflow, same cycle
//   data_result [31:0]        product low word / quotient, held between ops
//   data_exception            overflow or divide-by-zero, held with result
//   data_resultRDY            one-cycle completion pulse
//   busy                      high while an operation is in flight
// -----------------------------------------------------------------------------
module alu_muldiv_seq (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] alu_opA,
    output logic [31:0] alu_opB,
    output logic [4:0]  alu_opcode,
    output logic [4:0]  alu_shamt,
    input  logic [31:0] alu_result,
    input  logic        alu_overflow,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE, M_ITER, D_NEGA, D_NEGB, D_ITER, D_FIX, DONE
    } state_t;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;

    state_t      state;
    logic [4:0]  count;
    // Shared datapath:
    //   multiply: p_hi/p_lo/q_bit form the 65-bit Booth register, m = A
    //   divide:   p_hi = remainder R, p_lo = quotient Q (starts as |A|), m = |B|
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    logic [31:0] m;
    logic        q_bit;
    logic        sign;

    // Multiply step: arithmetic shift right of {alu_result, p_lo, q_bit}.
    // The true sign of the 33-bit sum is result MSB corrected by overflow.
    logic [1:0]  booth;
    logic [31:0] mult_hi_next;
    logic [31:0] mult_lo_next;
    logic        mult_exc;

    assign booth        = {p_lo[0], q_bit};
    assign mult_hi_next = {alu_result[31] ^ alu_overflow, alu_result[31:1]};
    assign mult_lo_next = {alu_result[0], p_lo[31:1]};
    assign mult_exc     = (mult_hi_next != {32{mult_lo_next[31]}});

    // Divide step: R' = {R, next dividend bit}; ALU computes R' - D.
    // R < D <= 2^31 keeps R' within 32 bits, so an unsigned borrow suffices.
    logic [31:0] r_shift;
    logic        borrow;

    assign r_shift = {p_hi[30:0], p_lo[31]};
    assign borrow  = (~r_shift[31] & m[31]) |
                     (~(r_shift[31] ^ m[31]) & alu_result[31]);

    assign alu_shamt = 5'd0;

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        alu_opA    = '0;
        alu_opB    = '0;
        alu_opcode = OP_ADD;
        case (state)
            M_ITER: begin
                alu_opA = p_hi;
                case (booth)
                    2'b01:   alu_opB = m;
                    2'b10: begin
                        alu_opB    = m;
                        alu_opcode = OP_SUB;
                    end
                    default: alu_opB = '0;
                endcase
            end
            D_NEGA: begin
                alu_opB    = p_lo;
                alu_opcode = OP_SUB;
            end
            D_NEGB: begin
                alu_opB    = m;
                alu_opcode = OP_SUB;
            end
            D_ITER: begin
                alu_opA    = r_shift;
                alu_opB    = m;
                alu_opcode = OP_SUB;
            end
            D_FIX: begin
                alu_opB    = p_lo;
                alu_opcode = OP_SUB;
            end
            default: ;
        endcase
    end

    // NOTE: all state is written with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            count          <= '0;
            p_hi           <= '0;
            p_lo           <= '0;
            m              <= '0;
            q_bit          <= 1'b0;
            sign           <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (ctrl_MULT) begin
                        state <= M_ITER;
                        busy  <= 1'b1;
                        count <= '0;
                        m     <= data_operandA;
                        p_hi  <= '0;
                        p_lo  <= data_operandB;
                        q_bit <= 1'b0;
                    end else if (ctrl_DIV) begin
                        if (data_operandB == 32'd0) begin
                            state          <= DONE;
                            data_result    <= '0;
                            data_exception <= 1'b1;
                            data_resultRDY <= 1'b1;
                        end else begin
                            state <= D_NEGA;
                            busy  <= 1'b1;
                            p_lo  <= data_operandA;
                            m     <= data_operandB;
                            sign  <= data_operandA[31] ^ data_operandB[31];
                        end
                    end
                end
                M_ITER: begin
                    p_hi  <= mult_hi_next;
                    p_lo  <= mult_lo_next;
                    q_bit <= p_lo[0];
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        state          <= DONE;
                        busy           <= 1'b0;
                        data_result    <= mult_lo_next;
                        data_exception <= mult_exc;
                        data_resultRDY <= 1'b1;
                    end
                end
                // Both negate states always run so divide latency is fixed.
                D_NEGA: begin
                    if (p_lo[31]) p_lo <= alu_result;
                    state <= D_NEGB;
                end
                D_NEGB: begin
                    if (m[31]) m <= alu_result;
                    p_hi  <= '0;
                    count <= '0;
                    state <= D_ITER;
                end
                D_ITER: begin
                    p_hi  <= borrow ? r_shift : alu_result;
                    p_lo  <= {p_lo[30:0], ~borrow};
                    count <= count + 5'd1;
                    if (count == 5'd31) state <= D_FIX;
                end
                // An unsigned quotient of 2^31 with positive sign can only
                // come from -2^31 / -1; Q already holds 0x80000000 then.
                D_FIX: begin
                    state          <= DONE;
                    busy           <= 1'b0;
                    data_result    <= sign ? alu_result : p_lo;
                    data_exception <= ~sign & p_lo[31];
                    data_resultRDY <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_muldiv_seq
//
// Self-checking bench for alu_muldiv_seq. Provides a combinational add/sub
// ALU, drives directed and random multiply/divide requests, and compares
// result, exception, completion latency and busy duration against an
// arithmetic reference model (64-bit product, truncating signed division).
// Latency is counted in rising edges after the start edge at which RDY rises.
// -----------------------------------------------------------------------------
module tb_alu_muldiv_seq;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] alu_opA, alu_opB, alu_result, data_result;
    logic [4:0]  alu_opcode, alu_shamt;
    logic        alu_overflow, data_exception, data_resultRDY, busy;

    int checks = 0;
    int errors = 0;

    localparam int TIMEOUT = 100;

    alu_muldiv_seq dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .alu_opA        (alu_opA),
        .alu_opB        (alu_opB),
        .alu_opcode     (alu_opcode),
        .alu_shamt      (alu_shamt),
        .alu_result     (alu_result),
        .alu_overflow   (alu_overflow),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // Processor ALU: add for 00000, subtract for 00001, signed overflow flag.
    always_comb begin
        if (alu_opcode == 5'b00001) begin
            alu_result   = alu_opA - alu_opB;
            alu_overflow = (alu_opA[31] != alu_opB[31]) && (alu_result[31] != alu_opA[31]);
        end else begin
            alu_result   = alu_opA + alu_opB;
            alu_overflow = (alu_opA[31] == alu_opB[31]) && (alu_result[31] != alu_opA[31]);
        end
    end

    // Reference model: plain signed arithmetic on the operands.
    function automatic void model(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e,
                                  output int lat, output int bsy);
        longint p;
        int     qa;
        if (is_mul) begin
            p   = longint'($signed(a)) * longint'($signed(b));
            r   = p[31:0];
            e   = (p != longint'($signed(p[31:0])));
            lat = 32;
            bsy = 32;
        end else if (b == 32'd0) begin
            r   = 32'd0;
            e   = 1'b1;
            lat = 0;
            bsy = 0;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r   = 32'h8000_0000;
            e   = 1'b1;
            lat = 35;
            bsy = 35;
        end else begin
            qa  = int'($signed(a)) / int'($signed(b));
            r   = qa;
            e   = 1'b0;
            lat = 35;
            bsy = 35;
        end
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0: v = $urandom;
            1: begin
                v = $urandom_range(0, 40);
                if ($urandom_range(0, 1) == 1) v = -v;
            end
            2: case ($urandom_range(0, 4))
                0: v = 32'h8000_0000;
                1: v = 32'h7FFF_FFFF;
                2: v = 32'hFFFF_FFFF;
                3: v = 32'h0000_0001;
                default: v = 32'h0000_0000;
            endcase
            default: v = $urandom >> $urandom_range(0, 31);
        endcase
        return v;
    endfunction

    // Issue one request, scramble the operand inputs after the start edge,
    // then count edges until RDY (bounded) and how many samples saw busy.
    task automatic do_op(input logic mul, input logic dv, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic exc, output int lat, output int bsy);
        @(negedge clock);
        ctrl_MULT = mul;
        ctrl_DIV = dv;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        lat = 0;
        bsy = 0;
        while (!data_resultRDY && lat < TIMEOUT) begin
            if (busy) bsy++;
            @(posedge clock);
            #1;
            lat++;
        end
        res = data_result;
        exc = data_exception;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (data_result !== 32'd0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got result=%h exc=%b rdy=%b busy=%b want all 0",
                     data_result, data_exception, data_resultRDY, busy);
        end
        checks++;
        if (alu_opA !== 32'd0 || alu_opB !== 32'd0 || alu_opcode !== 5'd0 || alu_shamt !== 5'd0) begin
            errors++;
            $display("FAIL reset_alu_drive got opA=%h opB=%h op=%b shamt=%b want all 0",
                     alu_opA, alu_opB, alu_opcode, alu_shamt);
        end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (busy !== 1'b0 || data_resultRDY !== 1'b0) begin
            errors++;
            $display("FAIL idle_quiet got busy=%b rdy=%b want 0 0", busy, data_resultRDY);
        end
    endtask

    // Directed cases first, then random operands; is_mul selects the operation.
    task automatic test_arith(input bit is_mul, input int n_random);
        logic [31:0] da [4];
        logic [31:0] db [4];
        logic [31:0] a, b, res, er;
        logic        exc, ee;
        int          lat, bsy, el, eb;
        if (is_mul) begin
            da = '{32'd7, 32'h0001_0000, 32'h8000_0000, 32'h8000_0000};
            db = '{32'hFFFF_FFFD, 32'h0001_0000, 32'hFFFF_FFFF, 32'h0000_0001};
        end else begin
            da = '{32'hFFFF_FFF9, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FF9C};
            db = '{32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7};
        end
        for (int i = 0; i < 4 + n_random; i++) begin
            a = (i < 4) ? da[i] : rand_operand();
            b = (i < 4) ? db[i] : rand_operand();
            model(is_mul, a, b, er, ee, el, eb);
            do_op(is_mul, !is_mul, a, b, res, exc, lat, bsy);
            checks++;
            if (res !== er || exc !== ee) begin
                errors++;
                $display("FAIL %s_result a=%h b=%h got %h/%b want %h/%b",
                         is_mul ? "mul" : "div", a, b, res, exc, er, ee);
            end
            checks++;
            if (lat != el || bsy != eb) begin
                errors++;
                $display("FAIL %s_timing a=%h b=%h got lat=%0d busy=%0d want lat=%0d busy=%0d",
                         is_mul ? "mul" : "div", a, b, lat, bsy, el, eb);
            end
            @(posedge clock);
            #1;
            checks++;
            if (data_resultRDY !== 1'b0 || data_result !== er || data_exception !== ee) begin
                errors++;
                $display("FAIL %s_hold got rdy=%b result=%h exc=%b want 0 %h %b",
                         is_mul ? "mul" : "div", data_resultRDY, data_result, data_exception, er, ee);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        logic        exc;
        int          lat, bsy;
        do_op(1'b0, 1'b1, 32'd5, 32'd0, res, exc, lat, bsy);
        checks++;
        if (res !== 32'd0 || exc !== 1'b1 || lat != 0) begin
            errors++;
            $display("FAIL div_by_zero got %h/%b lat=%0d want 00000000/1 lat=0", res, exc, lat);
        end
        // Still inside the RDY cycle: request the next divide now.
        ctrl_DIV = 1'b1;
        data_operandA = 32'd6;
        data_operandB = 32'd3;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        lat = 0;
        while (!data_resultRDY && lat < TIMEOUT) begin
            @(posedge clock);
            #1;
            lat++;
        end
        checks++;
        if (data_result !== 32'd2 || data_exception !== 1'b0 || lat != 35) begin
            errors++;
            $display("FAIL back_to_back got %h/%b lat=%0d want 00000002/0 lat=35",
                     data_result, data_exception, lat);
        end
    endtask

    task automatic test_priority_and_ignore();
        logic [31:0] res;
        logic        exc;
        int          lat, bsy;
        do_op(1'b1, 1'b1, 32'd6, 32'd4, res, exc, lat, bsy);
        checks++;
        if (res !== 32'd24 || exc !== 1'b0 || lat != 32) begin
            errors++;
            $display("FAIL mul_priority got %h/%b lat=%0d want 00000018/0 lat=32", res, exc, lat);
        end
        @(negedge clock);
        ctrl_MULT = 1'b1;
        data_operandA = 32'd6;
        data_operandB = 32'd4;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        lat = 0;
        while (!data_resultRDY && lat < TIMEOUT) begin
            if (lat == 10) begin
                ctrl_DIV = 1'b1;
                data_operandA = 32'd1000;
                data_operandB = 32'd3;
            end else begin
                ctrl_DIV = 1'b0;
            end
            @(posedge clock);
            #1;
            lat++;
        end
        ctrl_DIV = 1'b0;
        checks++;
        if (data_result !== 32'd24 || data_exception !== 1'b0 || lat != 32) begin
            errors++;
            $display("FAIL ignore_mid_request got %h/%b lat=%0d want 00000018/0 lat=32",
                     data_result, data_exception, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        logic        exc;
        int          lat, bsy, seen;
        @(negedge clock);
        ctrl_DIV = 1'b1;
        data_operandA = 32'd100;
        data_operandB = 32'd7;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        checks++;
        if (busy !== 1'b1 || alu_opcode !== 5'b00001) begin
            errors++;
            $display("FAIL mid_div_active got busy=%b op=%b want 1 00001", busy, alu_opcode);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (data_result !== 32'd0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0 || busy !== 1'b0 ||
            alu_opA !== 32'd0 || alu_opB !== 32'd0 || alu_opcode !== 5'd0) begin
            errors++;
            $display("FAIL async_reset got result=%h exc=%b rdy=%b busy=%b opA=%h opB=%h op=%b want all 0",
                     data_result, data_exception, data_resultRDY, busy, alu_opA, alu_opB, alu_opcode);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL no_rdy_after_reset got %0d pulses want 0", seen);
        end
        do_op(1'b1, 1'b0, 32'd3, 32'd5, res, exc, lat, bsy);
        checks++;
        if (res !== 32'd15 || exc !== 1'b0 || lat != 32) begin
            errors++;
            $display("FAIL mul_after_reset got %h/%b lat=%0d want 0000000f/0 lat=32", res, exc, lat);
        end
    endtask

    initial begin
        test_reset();
        test_arith(1'b1, 16);
        test_arith(1'b0, 16);
        test_back_to_back();
        test_priority_and_ignore();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
